// File: rtl/serial_adder_pkg.sv
// ---------------------------------------------------------------------------
// serial_adder_pkg
// Shared definitions for the bit-serial adder:
//   - sa_state_e   : controller states IDLE -> RUN -> DONE -> IDLE
//   - SA_W_DEFAULT : default operand/result width
// Optional feature macro used by the files importing this package:
//   SERIAL_ADD_OVF_EN (adds the signed-overflow output ovf)
// ---------------------------------------------------------------------------
package serial_adder_pkg;

   localparam int SA_W_DEFAULT = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sa_state_e;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_fsm_if.sv
// ---------------------------------------------------------------------------
// serial_adder_fsm_if
// Operand and result handshakes of the bit-serial adder.
//   in_valid/in_ready   : operand handshake (a, b, cin)
//   out_valid/out_ready : result handshake (sum, cout[, ovf])
// Modports:
//   master : producer of operands / consumer of results
//   slave  : the adder itself
// Macro SERIAL_ADD_OVF_EN adds the ovf signal to both modports.
// ---------------------------------------------------------------------------
interface serial_adder_fsm_if #(
   parameter int W = 8
);

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
`ifdef SERIAL_ADD_OVF_EN
   logic         ovf;
`endif

`ifdef SERIAL_ADD_OVF_EN
   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );

   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );
`else
   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout
   );

   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout
   );
`endif

endinterface : serial_adder_fsm_if

// File: rtl/serial_adder_fsm_full_add_cell.sv
// ---------------------------------------------------------------------------
// full_add_cell
// Combinational one-bit full adder used for each serial step.
//   a, b : operand bits
//   c    : carry in
//   s    : sum bit
//   co   : carry out
// ---------------------------------------------------------------------------
module full_add_cell (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic s,
   output logic co
);

   logic ab_x_s;

   assign ab_x_s = a ^ b;
   assign s      = ab_x_s ^ c;
   // Carry propagates through c only when exactly one operand bit is set.
   assign co     = (a & b) | (c & ab_x_s);

endmodule : full_add_cell

// File: rtl/serial_adder_fsm.sv
// ---------------------------------------------------------------------------
// serial_adder_fsm
// Bit-serial, LSB-first W-bit adder. Operands are captured in IDLE, one
// full-add step runs per clock in RUN, and the result is offered in DONE
// until the consumer accepts it.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : serial_adder_fsm_if.slave
//           in_valid/in_ready, a, b, cin   (operands, in_ready only in IDLE)
//           out_valid/out_ready, sum, cout (result, out_valid only in DONE)
//           ovf                            (only with SERIAL_ADD_OVF_EN)
// Parameter:
//   W     : operand/result width, W >= 2
// Macro SERIAL_ADD_OVF_EN adds a signed-overflow flag captured on entry
// to DONE.
// ---------------------------------------------------------------------------
module serial_adder_fsm
   import serial_adder_pkg::*;
#(
   parameter int W = SA_W_DEFAULT
) (
   input  logic               clk,
   input  logic               rst_n,
   serial_adder_fsm_if.slave  bus
);

   localparam int            CW       = $clog2(W);
   localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

   sa_state_e     state_r;
   sa_state_e     state_nxt_s;

   logic [W-1:0]  a_sh_r;
   logic [W-1:0]  b_sh_r;
   logic [W-1:0]  sum_r;
   logic          carry_r;
   logic          cout_r;
   logic [CW-1:0] cnt_r;
   logic          in_ready_r;
   logic          out_valid_r;

   logic          accept_s;
   logic          step_s;
   logic          last_s;
   logic          s_s;
   logic          co_s;

`ifdef SERIAL_ADD_OVF_EN
   logic          ovf_r;
`endif

   // Single full-add cell shared by every step of the serial addition.
   full_add_cell u_cell (
      .a  (a_sh_r[0]),
      .b  (b_sh_r[0]),
      .c  (carry_r),
      .s  (s_s),
      .co (co_s)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic and per-state datapath strobes.
   always_comb begin
      state_nxt_s = state_r;
      accept_s    = 1'b0;
      step_s      = 1'b0;
      last_s      = 1'b0;
      case (state_r)
         IDLE: begin
            accept_s = bus.in_valid;
            if (bus.in_valid) begin
               state_nxt_s = RUN;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         RUN: begin
            step_s = 1'b1;
            last_s = (cnt_r == CNT_LAST);
            if (cnt_r == CNT_LAST) begin
               state_nxt_s = DONE;
            end else begin
               state_nxt_s = RUN;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = DONE;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Operand shift registers, carry flop, step counter and result capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh_r  <= {W{1'b0}};
         b_sh_r  <= {W{1'b0}};
         sum_r   <= {W{1'b0}};
         carry_r <= 1'b0;
         cout_r  <= 1'b0;
         cnt_r   <= {CW{1'b0}};
      end else if (accept_s) begin
         a_sh_r  <= bus.a;
         b_sh_r  <= bus.b;
         carry_r <= bus.cin;
         cnt_r   <= {CW{1'b0}};
      end else if (step_s) begin
         a_sh_r  <= {1'b0, a_sh_r[W-1:1]};
         b_sh_r  <= {1'b0, b_sh_r[W-1:1]};
         // New bit enters at the MSB so the LSB-first stream lands in place
         // after W steps.
         sum_r   <= {s_s, sum_r[W-1:1]};
         carry_r <= co_s;
         if (last_s) begin
            // Counter parks on its last value instead of wrapping.
            cout_r <= co_s;
            cnt_r  <= cnt_r;
         end else begin
            cout_r <= cout_r;
            cnt_r  <= cnt_r + CW'(1);
         end
      end
   end

`ifdef SERIAL_ADD_OVF_EN
   // Signed overflow: carry into the MSB differs from carry out of it.
   // carry_r still holds the carry into bit W-1 during the last step.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_r <= 1'b0;
      end else if (step_s && last_s) begin
         ovf_r <= carry_r ^ co_s;
      end
   end

   assign bus.ovf = ovf_r;
`endif

   // Handshake flags registered from the next state so they align with it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
      end else begin
         in_ready_r  <= (state_nxt_s == IDLE);
         out_valid_r <= (state_nxt_s == DONE);
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.sum       = sum_r;
   assign bus.cout      = cout_r;

endmodule : serial_adder_fsm

// File: tb/tb_serial_adder_fsm.sv
// ---------------------------------------------------------------------------
// tb_serial_adder_fsm
// Self-checking bench for serial_adder_fsm (W=8). Expected results come from
// integer arithmetic and are queued at operand acceptance; a monitor pops
// and compares whenever a result handshake occurs.
// Macro SERIAL_ADD_OVF_EN also enables checking of ovf.
// ---------------------------------------------------------------------------
module tb_serial_adder_fsm;

   localparam int W = 8;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } exp_t;

   logic clk;
   logic rst_n;

   int   total;
   int   bad;
   int   pushed;
   int   popped;
   exp_t exp_q[$];
   exp_t mon_e;

   serial_adder_fsm_if #(.W(W)) bus ();

   serial_adder_fsm #(.W(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   // Reference: plain unsigned and signed integer arithmetic.
   function automatic exp_t ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      exp_t r;
      int   u;
      int   sx;
      int   sy;
      int   t;
      u  = int'(x) + int'(y) + int'(c);
      r.sum  = W'(u % (2 ** W));
      r.cout = (u >= (2 ** W));
      sx = (int'(x) >= 2 ** (W - 1)) ? int'(x) - 2 ** W : int'(x);
      sy = (int'(y) >= 2 ** (W - 1)) ? int'(y) - 2 ** W : int'(y);
      t  = sx + sy + int'(c);
      r.ovf = (t > (2 ** (W - 1)) - 1) || (t < -(2 ** (W - 1)));
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: compare on every result handshake.
   always @(negedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_result: got sum %0h with empty queue", bus.sum);
         end else begin
            mon_e = exp_q.pop_front();
            popped++;
            chk("sum", 32'(bus.sum), 32'(mon_e.sum));
            chk("cout", 32'(bus.cout), 32'(mon_e.cout));
`ifdef SERIAL_ADD_OVF_EN
            chk("ovf", 32'(bus.ovf), 32'(mon_e.ovf));
`endif
         end
      end
   end

   // One full transaction: accept, run (with ignored in_valid pulses),
   // optional DONE stall of 'hold' cycles, then result handshake.
   task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc, input int hold);
      exp_t r;
      int   n;
      int   lat;
      r = ref_add(ta, tb_v, tc);
      n = 0;
      while (!bus.in_ready && n < 4 * W) begin
         @(posedge clk); #1;
         n++;
      end
      chk("in_ready_wait", 32'(bus.in_ready), 32'd1);
      bus.a        = ta;
      bus.b        = tb_v;
      bus.cin      = tc;
      bus.in_valid = 1'b1;
      exp_q.push_back(r);
      pushed++;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.a        = W'($urandom);
      bus.b        = W'($urandom);
      bus.cin      = 1'($urandom);
      lat = 0;
      while (!bus.out_valid && lat < 3 * W) begin
         chk("in_ready_run", 32'(bus.in_ready), 32'd0);
         bus.in_valid = 1'($urandom);
         @(posedge clk); #1;
         lat++;
      end
      bus.in_valid = 1'b0;
      chk("latency", 32'(lat), 32'(W));
      for (int i = 0; i < hold; i++) begin
         chk("hold_valid", 32'(bus.out_valid), 32'd1);
         chk("hold_ready", 32'(bus.in_ready), 32'd0);
         chk("hold_sum", 32'(bus.sum), 32'(r.sum));
         chk("hold_cout", 32'(bus.cout), 32'(r.cout));
         @(posedge clk); #1;
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      chk("idle_valid", 32'(bus.out_valid), 32'd0);
      chk("idle_ready", 32'(bus.in_ready), 32'd1);
   endtask

   initial begin
      total  = 0;
      bad    = 0;
      pushed = 0;
      popped = 0;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.a         = {W{1'b0}};
      bus.b         = {W{1'b0}};
      bus.cin       = 1'b0;
      bus.out_ready = 1'b0;

      // Reset state.
      #12;
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_sum", 32'(bus.sum), 32'd0);
      chk("rst_cout", 32'(bus.cout), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
      chk("rst_ovf", 32'(bus.ovf), 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed vectors.
      send(8'h35, 8'h1A, 1'b0, 0);
      send(8'hFF, 8'h01, 1'b0, 0);
      send(8'h7F, 8'h01, 1'b0, 2);
      send(8'hFF, 8'hFF, 1'b1, 0);
      send(8'h80, 8'h80, 1'b0, 5);
      send(8'h00, 8'h00, 1'b0, 1);

      // Randomized operands and stall lengths.
      for (int k = 0; k < 24; k++) begin
         send(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
      end

      // Abort in the third RUN cycle.
      bus.a        = 8'h55;
      bus.b        = 8'h22;
      bus.cin      = 1'b0;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_valid", 32'(bus.out_valid), 32'd0);
      chk("abort_ready", 32'(bus.in_ready), 32'd1);
      chk("abort_sum", 32'(bus.sum), 32'd0);
      chk("abort_cout", 32'(bus.cout), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      send(8'h10, 8'h20, 1'b0, 0);

      repeat (3) @(posedge clk);
      #1;
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      chk("results_seen", 32'(popped), 32'(pushed));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_serial_adder_fsm
